// File: rtl/vga_line_fetch.sv
// Line-buffer filler: reads one RGB565 VGA line from SDRAM in fixed bursts into ping-pong buffers A/B.
// Define LINE_FETCH_STATS_EN to build the saturating aborted-line counter on abort_cnt.

module vga_line_fetch #(
  parameter int BURST_LEN  = 128,
  parameter int LINE_SHIFT = 10
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        vga_mode,
  input  logic        read_line_req,
  input  logic        read_line_A_B,
  input  logic [11:0] read_line_addr,
  output logic        mem_req,
  output logic [21:0] mem_addr,
  input  logic        mem_ack,
  input  logic        mem_rvalid,
  input  logic [15:0] mem_rdata,
  output logic        buf_wr_en_a,
  output logic        buf_wr_en_b,
  output logic [9:0]  buf_wr_addr,
  output logic [15:0] buf_wr_data,
  output logic        busy,
  output logic        overrun,
  output logic [15:0] abort_cnt
);

  localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int IDX_W  = ((1024 / BURST_LEN) > 1) ? $clog2(1024 / BURST_LEN) : 1;
  localparam logic [IDX_W-1:0]  LAST_640  = IDX_W'(640 / BURST_LEN - 1);
  localparam logic [IDX_W-1:0]  LAST_1024 = IDX_W'(1024 / BURST_LEN - 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    DATA,
    DRAIN,
    DONE
  } state_t;

  state_t            state_q, state_d;
  logic              sync1_q, sync1_d;
  logic              sync2_q, sync2_d;
  logic              sync3_q, sync3_d;
  logic              rise_q, rise_d;
  logic              ab_q, ab_d;
  logic [21:0]       base_q, base_d;
  logic [IDX_W-1:0]  last_idx_q, last_idx_d;
  logic [IDX_W-1:0]  burst_idx_q, burst_idx_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [9:0]        wr_ptr_q, wr_ptr_d;
  logic              wr_en_a_q, wr_en_a_d;
  logic              wr_en_b_q, wr_en_b_d;
  logic [9:0]        wr_addr_q, wr_addr_d;
  logic [15:0]       wr_data_q, wr_data_d;
  logic              overrun_q, overrun_d;
  logic              abort;

  always_comb begin
    sync1_d     = read_line_req;
    sync2_d     = sync1_q;
    sync3_d     = sync2_q;
    rise_d      = sync2_q & ~sync3_q;
    state_d     = state_q;
    ab_d        = ab_q;
    base_d      = base_q;
    last_idx_d  = last_idx_q;
    burst_idx_d = burst_idx_q;
    beat_d      = beat_q;
    wr_ptr_d    = wr_ptr_q;
    wr_en_a_d   = 1'b0;
    wr_en_b_d   = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    abort       = 1'b0;

    case (state_q)
      IDLE: begin
        if (rise_q) begin
          ab_d        = read_line_A_B;
          base_d      = 22'(read_line_addr) << LINE_SHIFT;
          last_idx_d  = vga_mode ? LAST_1024 : LAST_640;
          burst_idx_d = '0;
          beat_d      = '0;
          wr_ptr_d    = '0;
          state_d     = REQ;
        end
      end
      REQ: begin
        // An ack in the same cycle as the abort still commits us to draining that burst.
        if (mem_ack) begin
          beat_d  = '0;
          abort   = ~sync2_q;
          state_d = sync2_q ? DATA : DRAIN;
        end else if (!sync2_q) begin
          abort   = 1'b1;
          state_d = IDLE;
        end
      end
      DATA: begin
        abort = ~sync2_q;
        if (mem_rvalid) begin
          beat_d = beat_q + BEAT_W'(1);
          if (sync2_q) begin
            wr_en_a_d = ~ab_q;
            wr_en_b_d = ab_q;
            wr_addr_d = wr_ptr_q;
            wr_data_d = mem_rdata;
            wr_ptr_d  = wr_ptr_q + 10'd1;
          end
          if (beat_q == LAST_BEAT) begin
            if (!sync2_q) begin
              state_d = IDLE;
            end else if (burst_idx_q == last_idx_q) begin
              state_d = DONE;
            end else begin
              burst_idx_d = burst_idx_q + IDX_W'(1);
              state_d     = REQ;
            end
          end else if (!sync2_q) begin
            state_d = DRAIN;
          end
        end else if (!sync2_q) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (mem_rvalid) begin
          beat_d = beat_q + BEAT_W'(1);
          if (beat_q == LAST_BEAT) begin
            state_d = IDLE;
          end
        end
      end
      DONE: begin
        if (!sync2_q) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    overrun_d = overrun_q | abort;
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q     <= IDLE;
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      sync3_q     <= 1'b0;
      rise_q      <= 1'b0;
      ab_q        <= 1'b0;
      base_q      <= '0;
      last_idx_q  <= '0;
      burst_idx_q <= '0;
      beat_q      <= '0;
      wr_ptr_q    <= '0;
      wr_en_a_q   <= 1'b0;
      wr_en_b_q   <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      sync3_q     <= sync3_d;
      rise_q      <= rise_d;
      ab_q        <= ab_d;
      base_q      <= base_d;
      last_idx_q  <= last_idx_d;
      burst_idx_q <= burst_idx_d;
      beat_q      <= beat_d;
      wr_ptr_q    <= wr_ptr_d;
      wr_en_a_q   <= wr_en_a_d;
      wr_en_b_q   <= wr_en_b_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      overrun_q   <= overrun_d;
    end
  end

`ifdef LINE_FETCH_STATS_EN
  logic [15:0] abort_cnt_q, abort_cnt_d;

  always_comb begin
    abort_cnt_d = abort_cnt_q;
    if (abort && (abort_cnt_q != 16'hFFFF)) begin
      abort_cnt_d = abort_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      abort_cnt_q <= '0;
    end else begin
      abort_cnt_q <= abort_cnt_d;
    end
  end

  assign abort_cnt = abort_cnt_q;
`else
  assign abort_cnt = 16'd0;
`endif

  assign mem_req     = (state_q == REQ);
  assign mem_addr    = base_q + (22'(burst_idx_q) << BEAT_W);
  assign buf_wr_en_a = wr_en_a_q;
  assign buf_wr_en_b = wr_en_b_q;
  assign buf_wr_addr = wr_addr_q;
  assign buf_wr_data = wr_data_q;
  assign busy        = (state_q != IDLE);
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_vga_line_fetch.sv
// Testbench for vga_line_fetch: SDRAM responder, write capture, and a line-level reference model.
// Honours LINE_FETCH_STATS_EN for the expected abort_cnt.

module tb_vga_line_fetch;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic        vga_mode;
  logic        read_line_req;
  logic        read_line_A_B;
  logic [11:0] read_line_addr;
  logic        mem_req;
  logic [21:0] mem_addr;
  logic        mem_ack;
  logic        mem_rvalid;
  logic [15:0] mem_rdata;
  logic        buf_wr_en_a;
  logic        buf_wr_en_b;
  logic [9:0]  buf_wr_addr;
  logic [15:0] buf_wr_data;
  logic        busy;
  logic        overrun;
  logic [15:0] abort_cnt;

  vga_line_fetch dut (
    .sys_clk       (sys_clk),
    .sys_rst_n     (sys_rst_n),
    .vga_mode      (vga_mode),
    .read_line_req (read_line_req),
    .read_line_A_B (read_line_A_B),
    .read_line_addr(read_line_addr),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .mem_ack       (mem_ack),
    .mem_rvalid    (mem_rvalid),
    .mem_rdata     (mem_rdata),
    .buf_wr_en_a   (buf_wr_en_a),
    .buf_wr_en_b   (buf_wr_en_b),
    .buf_wr_addr   (buf_wr_addr),
    .buf_wr_data   (buf_wr_data),
    .busy          (busy),
    .overrun       (overrun),
    .abort_cnt     (abort_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic        b;
    logic [9:0]  addr;
    logic [15:0] data;
  } wr_t;

  wr_t         wq[$];
  logic [21:0] q_addr[$];
  int          both_hi = 0;
  int          nvec = 0;
  int          nerr = 0;

  int res_lat, res_timeouts, res_drop_bad, res_extra;
  logic res_busy_done, res_busy_idle;

  // Every buffer write the DUT makes, in order, as seen by the line RAMs.
  always @(negedge sys_clk) begin
    if (buf_wr_en_a === 1'b1 && buf_wr_en_b === 1'b1) both_hi++;
    if (buf_wr_en_a === 1'b1 || buf_wr_en_b === 1'b1)
      wq.push_back('{b: buf_wr_en_b, addr: buf_wr_addr, data: buf_wr_data});
  end

  function automatic logic [15:0] mem_word(input logic [21:0] a);
    logic [15:0] w;
    w = a[15:0] ^ {a[21:16], a[21:12]} ^ 16'h5A3C;
    return w;
  endfunction

  // Index of the first captured write that disagrees with the expected line, or -1.
  function automatic int first_bad(input int n, input logic ab, input int base);
    for (int i = 0; i < n; i++) begin
      if (i >= wq.size()) return i;
      if (wq[i].b !== ab || wq[i].addr !== 10'(i) || wq[i].data !== mem_word(22'(base + i))) return i;
    end
    return -1;
  endfunction

  task automatic wait_req(output int waited);
    bit found;
    found  = 1'b0;
    waited = -1;
    for (int t = 0; t < 300 && !found; t++) begin
      @(negedge sys_clk);
      if (mem_req === 1'b1) begin
        found  = 1'b1;
        waited = t;
      end
    end
  endtask

  task automatic ack_req(input int dly, output logic still_req);
    repeat (dly) @(negedge sys_clk);
    mem_ack = 1'b1;
    @(negedge sys_clk);
    mem_ack   = 1'b0;
    still_req = mem_req;
  endtask

  task automatic send_beats(input logic [21:0] a, input int from, input int to, input int gap_max);
    for (int b = from; b < to; b++) begin
      repeat ($urandom_range(gap_max, 0)) @(negedge sys_clk);
      mem_rvalid = 1'b1;
      mem_rdata  = mem_word(a + 22'(b));
      @(negedge sys_clk);
      mem_rvalid = 1'b0;
    end
  endtask

  task automatic test_reset;
    sys_rst_n      = 1'b0;
    vga_mode       = 1'b0;
    read_line_req  = 1'b0;
    read_line_A_B  = 1'b0;
    read_line_addr = '0;
    mem_ack        = 1'b0;
    mem_rvalid     = 1'b0;
    mem_rdata      = '0;
    repeat (3) @(negedge sys_clk);
    nvec++; if (mem_req !== 1'b0) begin nerr++; $display("[TB] FAIL reset_mem_req: got %b expected 0", mem_req); end
    nvec++; if (mem_addr !== 22'd0) begin nerr++; $display("[TB] FAIL reset_mem_addr: got %h expected 0", mem_addr); end
    nvec++; if (buf_wr_en_a !== 1'b0 || buf_wr_en_b !== 1'b0) begin nerr++; $display("[TB] FAIL reset_wr_en: got %b%b expected 00", buf_wr_en_a, buf_wr_en_b); end
    nvec++; if (buf_wr_addr !== 10'd0 || buf_wr_data !== 16'd0) begin nerr++; $display("[TB] FAIL reset_wr_bus: got %h/%h expected 0/0", buf_wr_addr, buf_wr_data); end
    nvec++; if (busy !== 1'b0 || overrun !== 1'b0) begin nerr++; $display("[TB] FAIL reset_status: busy %b overrun %b expected 0 0", busy, overrun); end
    nvec++; if (abort_cnt !== 16'd0) begin nerr++; $display("[TB] FAIL reset_abort_cnt: got %0d expected 0", abort_cnt); end
    sys_rst_n = 1'b1;
    repeat (2) @(negedge sys_clk);
  endtask

  // One whole line: request, serve every burst, release; glitch also perturbs the request mid-line.
  task automatic test_full_line(input string name, input logic mode, input logic [11:0] line,
                                input logic ab, input int ack_max, input int gap_max, input bit glitch);
    int nb, words, base, w, bad;
    logic still;
    nb    = mode ? 8 : 5;
    words = mode ? 1024 : 640;
    base  = int'(line) * 1024;
    read_line_req = 1'b0;
    repeat (4) @(negedge sys_clk);
    wq.delete();
    q_addr.delete();
    both_hi        = 0;
    res_lat        = -1;
    res_timeouts   = 0;
    res_drop_bad   = 0;
    res_extra      = 0;
    vga_mode       = mode;
    read_line_addr = line;
    read_line_A_B  = ab;
    read_line_req  = 1'b1;
    for (int k = 0; k < nb; k++) begin
      logic [21:0] a;
      wait_req(w);
      if (k == 0) res_lat = w;
      if (w < 0) begin
        res_timeouts++;
        break;
      end
      a = mem_addr;
      q_addr.push_back(a);
      ack_req($urandom_range(ack_max, 0), still);
      if (still !== 1'b0) res_drop_bad++;
      if (glitch && k == 1) begin
        send_beats(a, 0, 5, gap_max);
        read_line_req  = 1'b0;
        read_line_addr = ~line;
        read_line_A_B  = ~ab;
        #2;
        read_line_req  = 1'b1;
        send_beats(a, 5, 128, gap_max);
      end else begin
        send_beats(a, 0, 128, gap_max);
      end
    end
    for (int t = 0; t < 10; t++) begin
      @(negedge sys_clk);
      if (mem_req !== 1'b0) res_extra++;
    end
    res_busy_done = busy;
    read_line_req = 1'b0;
    repeat (3) @(negedge sys_clk);
    res_busy_idle = busy;

    nvec++; if (res_lat !== 3) begin nerr++; $display("[TB] FAIL %s latency: got %0d cycles expected 3", name, res_lat); end
    nvec++; if (res_timeouts !== 0) begin nerr++; $display("[TB] FAIL %s req_timeout: got %0d expected 0", name, res_timeouts); end
    nvec++; if (q_addr.size() !== nb) begin nerr++; $display("[TB] FAIL %s burst_count: got %0d expected %0d", name, q_addr.size(), nb); end
    bad = -1;
    for (int k = 0; k < q_addr.size(); k++)
      if (bad < 0 && q_addr[k] !== 22'(base + k * 128)) bad = k;
    nvec++; if (bad !== -1) begin nerr++; $display("[TB] FAIL %s burst_addr: burst %0d got %h expected %h", name, bad, q_addr[bad], 22'(base + bad * 128)); end
    nvec++; if (res_drop_bad !== 0) begin nerr++; $display("[TB] FAIL %s req_drop_after_ack: got %0d late drops expected 0", name, res_drop_bad); end
    nvec++; if (res_extra !== 0) begin nerr++; $display("[TB] FAIL %s extra_req: got %0d cycles expected 0", name, res_extra); end
    nvec++; if (wq.size() !== words) begin nerr++; $display("[TB] FAIL %s write_count: got %0d expected %0d", name, wq.size(), words); end
    bad = first_bad(words, ab, base);
    nvec++; if (bad !== -1) begin nerr++; $display("[TB] FAIL %s line_contents: first bad write %0d expected none", name, bad); end
    nvec++; if (both_hi !== 0) begin nerr++; $display("[TB] FAIL %s both_enables: got %0d cycles expected 0", name, both_hi); end
    nvec++; if (res_busy_done !== 1'b1) begin nerr++; $display("[TB] FAIL %s busy_done: got %b expected 1", name, res_busy_done); end
    nvec++; if (res_busy_idle !== 1'b0) begin nerr++; $display("[TB] FAIL %s busy_idle: got %b expected 0", name, res_busy_idle); end
  endtask

  // Request falls during the third burst, then rises again while that burst is still draining.
  task automatic test_abort;
    logic [11:0] line;
    logic ab, still;
    int base, w, extra, timeouts, bad, exp_cnt;
    line = 12'($urandom_range(4095, 0));
    ab   = 1'($urandom_range(1, 0));
    base = int'(line) * 1024;
    timeouts = 0;
    extra    = 0;
`ifdef LINE_FETCH_STATS_EN
    exp_cnt = 1;
`else
    exp_cnt = 0;
`endif
    read_line_req = 1'b0;
    repeat (4) @(negedge sys_clk);
    wq.delete();
    vga_mode       = 1'b0;
    read_line_addr = line;
    read_line_A_B  = ab;
    read_line_req  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      logic [21:0] a;
      wait_req(w);
      if (w < 0) begin
        timeouts++;
        break;
      end
      a = mem_addr;
      ack_req(0, still);
      if (k < 2) begin
        send_beats(a, 0, 128, 0);
      end else begin
        send_beats(a, 0, 10, 0);
        read_line_req = 1'b0;
        repeat (4) @(negedge sys_clk);
        read_line_addr = ~line;
        read_line_req  = 1'b1;
        repeat (4) @(negedge sys_clk);
        send_beats(a, 10, 128, 0);
      end
    end
    for (int t = 0; t < 60; t++) begin
      @(negedge sys_clk);
      if (mem_req !== 1'b0) extra++;
    end
    nvec++; if (timeouts !== 0) begin nerr++; $display("[TB] FAIL abort req_timeout: got %0d expected 0", timeouts); end
    nvec++; if (wq.size() !== 266) begin nerr++; $display("[TB] FAIL abort write_count: got %0d expected 266", wq.size()); end
    bad = first_bad(266, ab, base);
    nvec++; if (bad !== -1) begin nerr++; $display("[TB] FAIL abort contents: first bad write %0d expected none", bad); end
    nvec++; if (extra !== 0) begin nerr++; $display("[TB] FAIL abort no_restart: got %0d req cycles expected 0", extra); end
    nvec++; if (busy !== 1'b0) begin nerr++; $display("[TB] FAIL abort busy: got %b expected 0", busy); end
    nvec++; if (overrun !== 1'b1) begin nerr++; $display("[TB] FAIL abort overrun: got %b expected 1", overrun); end
    nvec++; if (abort_cnt !== 16'(exp_cnt)) begin nerr++; $display("[TB] FAIL abort abort_cnt: got %0d expected %0d", abort_cnt, exp_cnt); end
    read_line_req = 1'b0;
    repeat (4) @(negedge sys_clk);
  endtask

  task automatic test_reset_mid_burst;
    logic still;
    int w;
    read_line_req = 1'b0;
    repeat (4) @(negedge sys_clk);
    vga_mode       = 1'($urandom_range(1, 0));
    read_line_addr = 12'($urandom_range(4095, 0));
    read_line_A_B  = 1'($urandom_range(1, 0));
    read_line_req  = 1'b1;
    wait_req(w);
    nvec++; if (w < 0) begin nerr++; $display("[TB] FAIL rst_mid req_timeout: got %0d expected 3", w); end
    ack_req(0, still);
    send_beats(mem_addr, 0, 20, 0);
    mem_rvalid = 1'b1;
    mem_rdata  = 16'hBEEF;
    sys_rst_n  = 1'b0;
    @(negedge sys_clk);
    mem_rvalid = 1'b0;
    nvec++; if (mem_req !== 1'b0 || mem_addr !== 22'd0) begin nerr++; $display("[TB] FAIL rst_mid mem_if: got %b/%h expected 0/0", mem_req, mem_addr); end
    nvec++; if (buf_wr_en_a !== 1'b0 || buf_wr_en_b !== 1'b0) begin nerr++; $display("[TB] FAIL rst_mid wr_en: got %b%b expected 00", buf_wr_en_a, buf_wr_en_b); end
    nvec++; if (buf_wr_addr !== 10'd0 || buf_wr_data !== 16'd0) begin nerr++; $display("[TB] FAIL rst_mid wr_bus: got %h/%h expected 0/0", buf_wr_addr, buf_wr_data); end
    nvec++; if (busy !== 1'b0 || overrun !== 1'b0 || abort_cnt !== 16'd0) begin nerr++; $display("[TB] FAIL rst_mid status: busy %b overrun %b cnt %0d expected 0 0 0", busy, overrun, abort_cnt); end
    sys_rst_n     = 1'b1;
    read_line_req = 1'b0;
    repeat (4) @(negedge sys_clk);
  endtask

  initial begin
    test_reset();
    test_full_line("mode640_line5_B", 1'b0, 12'd5, 1'b1, 0, 0, 1'b0);
    test_full_line("mode1024_line4095_A", 1'b1, 12'd4095, 1'b0, 0, 0, 1'b0);
    for (int i = 0; i < 3; i++)
      test_full_line("random_waits", 1'($urandom_range(1, 0)), 12'($urandom_range(4095, 0)),
                     1'($urandom_range(1, 0)), 10, 3, 1'b0);
    test_full_line("repulse_in_data", 1'($urandom_range(1, 0)), 12'($urandom_range(4095, 0)),
                   1'($urandom_range(1, 0)), 2, 1, 1'b1);
    test_abort();
    test_reset_mid_burst();
    test_full_line("after_reset", 1'($urandom_range(1, 0)), 12'($urandom_range(4095, 0)),
                   1'($urandom_range(1, 0)), 3, 2, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/vga_line_fetch.md
# vga_line_fetch

Line-buffer filler for the VGA scan-out path. It responds to the display's per-line `read_line_req` / `read_line_A_B` / `read_line_addr` request and reads one 16-bit RGB565 line from the SDRAM framebuffer in fixed-length bursts. It writes each line into ping-pong line buffer A or B, which the display side reads back by pixel address. It runs entirely in the memory-controller clock domain and sits between the SDRAM arbiter read port and the two dual-port line RAMs.

## Interface
- `BURST_LEN`, 128: words per SDRAM read burst; power of two, divides 640 and 1024.
- `LINE_SHIFT`, 10: log2 of the framebuffer line pitch in words. Line base = `{line, 10'b0}`.
- `sys_clk` in 1: memory-domain clock.
- `sys_rst_n` in 1: reset, synchronous, active-low.
- `vga_mode` in 1: 0 = 640 words/line, 1 = 1024 words/line. Quasi-static; sampled at request capture.
- `read_line_req` in 1: line request level from the display domain; asynchronous to `sys_clk`.
- `read_line_A_B` in 1: target buffer, 0 = A, 1 = B. Stable while the request is high.
- `read_line_addr` in 12: framebuffer line number. Stable while the request is high.
- `mem_req` out 1: burst read request.
- `mem_addr` out 22: burst start word address.
- `mem_ack` in 1: one-cycle acceptance of `mem_req`.
- `mem_rvalid` in 1: read data valid strobe.
- `mem_rdata` in 16: read data.
- `buf_wr_en_a` out 1: write strobe, line buffer A.
- `buf_wr_en_b` out 1: write strobe, line buffer B.
- `buf_wr_addr` out 10: pixel index within the line.
- `buf_wr_data` out 16: pixel data.
- `busy` out 1: high in any state other than IDLE.
- `overrun` out 1: sticky; set when a line is aborted before completion; cleared only by reset.
- `abort_cnt` out 16: aborted-line counter; present only with the statistics option (see Configuration).

## Operation
- `read_line_req` passes through a 2-flop synchronizer, then a rising-edge detector. `read_line_A_B` and `read_line_addr` are sampled on the detected edge. They are not synchronized, because they are stable for the whole line.
- On capture:
  - `words` = 1024 if `vga_mode`, else 640.
  - `bursts` = `words / BURST_LEN`.
  - `base` = `read_line_addr << LINE_SHIFT`.
  - Write pointer cleared to 0.
- States:
  - IDLE: wait for the request edge, then go to REQ.
  - REQ: `mem_req` = 1 and `mem_addr` = `base + burst_idx*BURST_LEN`. On `mem_ack`, go to DATA.
  - DATA: each `mem_rvalid` writes `mem_rdata` to the selected buffer at the write pointer, then increments the pointer.
    - After `BURST_LEN` beats: if `burst_idx+1 == bursts`, go to DONE; else increment `burst_idx` and go to REQ.
  - DONE: wait until the synchronized request is low, then go to IDLE.
- Abort: if the synchronized request falls while in REQ or DATA:
  - `overrun` is set.
  - REQ without `mem_ack` in the same cycle: drop `mem_req` and go to IDLE.
  - REQ with `mem_ack` in the same cycle: the ack wins; go to DATA as in DATA below.
  - DATA: keep absorbing the current burst but suppress buffer writes, then go to IDLE. Accepted bursts are always drained.
- New request edges are ignored outside IDLE.
- Write pointer arithmetic is 10-bit and never wraps within a line. The last write address is 639 or 1023.
- `mem_addr` is 22-bit; `base + offset` cannot carry out for any legal line.
- `buf_wr_en_a` and `buf_wr_en_b` are never high together.

## Timing
- Reset values: `mem_req` 0, `mem_addr` 0, both write enables 0, `buf_wr_addr` 0, `buf_wr_data` 0, `busy` 0, `overrun` 0, `abort_cnt` 0. State is IDLE and the synchronizer flops are 0.
- Request latency: with `read_line_req` rising before sys_clk edge 0, the edge is detected at edge 2 and `mem_req` is high after edge 3.
- `mem_req` drops in the cycle after `mem_ack`. It is back up no earlier than the cycle after the final `mem_rvalid` of the previous burst.
- Buffer writes are registered: the write strobe, address and data appear 1 cycle after the `mem_rvalid` beat.
- `mem_rvalid` may be non-contiguous; gaps are tolerated.
- Reset mid-burst returns to IDLE immediately. Beats still in flight are the arbiter's responsibility.

## Configuration
- `LINE_FETCH_STATS_EN` defined:
  - `abort_cnt` counts aborted lines.
  - Increments once per abort and saturates at 16'hFFFF.
- `LINE_FETCH_STATS_EN` undefined:
  - Counter logic is removed and `abort_cnt` is tied to 0.
  - `overrun` is unaffected.

## Test plan
- Mode 640, line 5, B, zero-wait memory:
  - Exactly 5 `mem_req`/`mem_ack` handshakes, at `mem_addr` 0x1400, 0x1480, …, 0x1600.
  - 640 `buf_wr_en_b` writes, addresses 0..639; no A writes.
  - After the request drops, `busy` returns to 0.
- Mode 1024, line 4095, A:
  - 8 bursts; last `mem_addr` = 0x3FFF80.
  - Last write address 1023, data matching the memory model.
- Random 0–3-cycle `mem_rvalid` gaps and 0–10-cycle `mem_ack` delays:
  - Buffer contents are identical to the zero-wait run.
  - Request edge to first `mem_req` = 3 cycles.
- Request drops during burst 3 of 5:
  - Burst 3 is fully absorbed with no buffer writes; no 4th `mem_req`.
  - `overrun` = 1; `abort_cnt` = 1 with the macro, 0 without.
- Request re-pulsed while in DATA: no restart, and capture does not change.
- `sys_rst_n` asserted mid-burst:
  - All outputs return to reset values on the next edge.
  - A fresh request then completes normally.
